// File: rtl/sdbp_frame_tx.sv
// SDBP backlight packet transmitter: buffers one frame of zone values in a ping-pong RAM
// and serializes HDR, zone words and a 16-bit checksum on each sdbpflag rise.
// state | meaning
// IDLE  | waiting for an sdbpflag rise
// HDR   | shifting the header word
// DATA  | shifting zone words from the transmit bank
// CHK   | shifting the checksum word
// DONE  | frame_done cycle, back to IDLE next
module sdbp_frame_tx #(
    parameter int          N_ZONES  = 360,
    parameter int          CLK_DIV  = 2,
    parameter logic [15:0] HDR_WORD = 16'h5AA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wt_we,
    input  logic [9:0]  wtaddr,
    input  logic [15:0] wtdina,
    input  logic        sdbpflag,
    output logic        sdbp_cs_n,
    output logic        sdbp_sclk,
    output logic        sdbp_mosi,
    output logic        busy,
    output logic        frame_done,
    output logic        err_overrun
);
    localparam int AW  = $clog2(2 * N_ZONES + 1);
    localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WCW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam logic [AW-1:0]  MEM_DEPTH  = AW'(2 * N_ZONES);
    localparam logic [AW-1:0]  BANK1_BASE = AW'(N_ZONES);
    localparam logic [DW-1:0]  DIV_RELOAD = DW'(CLK_DIV - 1);
    localparam logic [WCW-1:0] LAST_WORDS = WCW'(N_ZONES - 1);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE} state_t;

    state_t         state;
    logic [15:0]    mem [0:2*N_ZONES-1];
    logic [15:0]    rd_data;
    logic [15:0]    chk_acc;
    logic [14:0]    shift_reg;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_idx;
    logic [DW-1:0]  div_cnt;
    logic [3:0]     bit_cnt;
    logic [WCW-1:0] word_cnt;
    logic           wr_bank;
    logic           sdbpflag_q;
    logic           rise;
    logic           wr_ok;

    assign rise   = sdbpflag & ~sdbpflag_q;
    assign wr_ok  = wt_we && ({1'b0, wtaddr} < 11'(N_ZONES));
    assign wr_idx = wr_bank ? BANK1_BASE + AW'(wtaddr) : AW'(wtaddr);

    // Bank 0 occupies [0, N_ZONES), bank 1 [N_ZONES, 2*N_ZONES); read side runs every cycle.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_idx] <= wtdina;
        if (rd_ptr < MEM_DEPTH)
            rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_bank     <= 1'b0;
            sdbpflag_q  <= 1'b0;
            sdbp_cs_n   <= 1'b1;
            sdbp_sclk   <= 1'b0;
            sdbp_mosi   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            rd_ptr      <= '0;
            shift_reg   <= '0;
            chk_acc     <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
        end else begin
            sdbpflag_q  <= sdbpflag;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= HDR;
                        wr_bank   <= ~wr_bank;
                        rd_ptr    <= wr_bank ? BANK1_BASE : '0;
                        chk_acc   <= '0;
                        busy      <= 1'b1;
                        sdbp_cs_n <= 1'b0;
                        sdbp_sclk <= 1'b0;
                        sdbp_mosi <= HDR_WORD[15];
                        shift_reg <= HDR_WORD[14:0];
                        bit_cnt   <= 4'd15;
                        div_cnt   <= DIV_RELOAD;
                    end
                end
                HDR, DATA, CHK: begin
                    err_overrun <= rise;
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt   <= DIV_RELOAD;
                        sdbp_sclk <= ~sdbp_sclk;
                        // Falling sclk: present the next bit, or cross a word boundary.
                        if (sdbp_sclk) begin
                            if (bit_cnt != '0) begin
                                bit_cnt   <= bit_cnt - 1'b1;
                                sdbp_mosi <= shift_reg[14];
                                shift_reg <= {shift_reg[13:0], 1'b0};
                            end else begin
                                bit_cnt <= 4'd15;
                                if (state == CHK) begin
                                    state      <= DONE;
                                    sdbp_cs_n  <= 1'b1;
                                    sdbp_mosi  <= 1'b0;
                                    busy       <= 1'b0;
                                    frame_done <= 1'b1;
                                end else if (state == DATA && word_cnt == '0) begin
                                    state     <= CHK;
                                    sdbp_mosi <= chk_acc[15];
                                    shift_reg <= chk_acc[14:0];
                                end else begin
                                    state     <= DATA;
                                    word_cnt  <= (state == HDR) ? LAST_WORDS : word_cnt - 1'b1;
                                    sdbp_mosi <= rd_data[15];
                                    shift_reg <= rd_data[14:0];
                                    chk_acc   <= chk_acc + rd_data;
                                    rd_ptr    <= rd_ptr + 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    err_overrun <= rise;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdbp_frame_tx.sv
// Bench for sdbp_frame_tx: expected SDBP words are queued at each request and compared
// against words reassembled from the serial pins by an independent monitor.
module tb_sdbp_frame_tx;
    localparam int N_ZONES   = 360;
    localparam int CLK_DIV   = 2;
    localparam int PKT_WORDS = N_ZONES + 2;
    localparam int LATENCY   = 23169;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wt_we = 1'b0;
    logic [9:0]  wtaddr = '0;
    logic [15:0] wtdina = '0;
    logic        sdbpflag = 1'b0;
    logic        sdbp_cs_n, sdbp_sclk, sdbp_mosi, busy, frame_done, err_overrun;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int pkt_no = 0;
    int done_count = 0;
    int ov_count = 0;
    int words_seen = 0;
    int bit_n = 0;
    logic [15:0] word_sr = '0;
    logic [15:0] exp_q[$];
    logic sclk_prev = 1'b0;
    logic ov_prev = 1'b0;
    logic done_prev = 1'b0;

    sdbp_frame_tx #(.N_ZONES(N_ZONES), .CLK_DIV(CLK_DIV), .HDR_WORD(16'h5AA5)) dut (
        .clk(clk),
        .rst(rst),
        .wt_we(wt_we),
        .wtaddr(wtaddr),
        .wtdina(wtdina),
        .sdbpflag(sdbpflag),
        .sdbp_cs_n(sdbp_cs_n),
        .sdbp_sclk(sdbp_sclk),
        .sdbp_mosi(sdbp_mosi),
        .busy(busy),
        .frame_done(frame_done),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: rebuilds words on rising sclk, pops the scoreboard, checks frame_done timing.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            bit_n = 0;
            words_seen = 0;
        end else begin
            if (sdbp_sclk && !sclk_prev && !sdbp_cs_n) begin
                word_sr = {word_sr[14:0], sdbp_mosi};
                bit_n++;
                if (bit_n == 16) begin
                    bit_n = 0;
                    if (exp_q.size() == 0)
                        fail_event($sformatf("pkt%0d_extra_word", pkt_no),
                                   $sformatf("got %0h, expected no word", word_sr));
                    else
                        check($sformatf("pkt%0d_word%0d", pkt_no, words_seen), word_sr, exp_q.pop_front());
                    words_seen++;
                end
            end
            if (frame_done && !done_prev) begin
                done_count++;
                check($sformatf("pkt%0d_latency", pkt_no), cyc - rise_cyc, LATENCY);
                check($sformatf("pkt%0d_word_count", pkt_no), words_seen, PKT_WORDS);
                check($sformatf("pkt%0d_queue_left", pkt_no), exp_q.size(), 0);
                words_seen = 0;
                bit_n = 0;
            end
            if (frame_done && done_prev)
                fail_event("frame_done_width", "got pulse longer than 1 cycle, expected 1");
            if (err_overrun && ov_prev)
                fail_event("err_overrun_width", "got pulse longer than 1 cycle, expected 1");
            if (err_overrun && !ov_prev)
                ov_count++;
        end
        sclk_prev = sdbp_sclk;
        ov_prev   = err_overrun;
        done_prev = frame_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wt_we  = 1'b1;
        wtaddr = 10'(a);
        wtdina = d;
        tick();
        wt_we  = 1'b0;
    endtask

    // kind 0: zone i = i; kind 1: all FFFF; kind 2: zone i = i except last zone = 7.
    task automatic push_pkt(input int kind);
        exp_q.push_back(16'h5AA5);
        for (int i = 0; i < N_ZONES; i++) begin
            case (kind)
                0:       exp_q.push_back(16'(i));
                1:       exp_q.push_back(16'hFFFF);
                default: exp_q.push_back((i == N_ZONES - 1) ? 16'h0007 : 16'(i));
            endcase
        end
        case (kind)
            0:       exp_q.push_back(16'hFC6C);
            1:       exp_q.push_back(16'hFE98);
            default: exp_q.push_back(16'hFB0C);
        endcase
    endtask

    task automatic send_rise(input int kind);
        pkt_no++;
        push_pkt(kind);
        sdbpflag = 1'b1;
        rise_cyc = cyc;
        tick();
        check($sformatf("pkt%0d_start_busy", pkt_no), busy, 1);
        check($sformatf("pkt%0d_start_cs_n", pkt_no), sdbp_cs_n, 0);
        check($sformatf("pkt%0d_start_sclk", pkt_no), sdbp_sclk, 0);
        check($sformatf("pkt%0d_start_mosi", pkt_no), sdbp_mosi, 0);
        repeat (3) tick();
        sdbpflag = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start = done_count;
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (done_count != start) got = 1'b1;
        end
        if (!got)
            fail_event("frame_done_timeout", $sformatf("got none within %0d cycles, expected one", budget));
        tick();
        tick();
    endtask

    initial begin
        int viol;
        int done_before;

        rst = 1'b1;
        repeat (3) tick();
        check("reset_cs_n", sdbp_cs_n, 1);
        check("reset_sclk", sdbp_sclk, 0);
        check("reset_mosi", sdbp_mosi, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_err_overrun", err_overrun, 0);
        rst = 1'b0;

        viol = 0;
        repeat (100) begin
            tick();
            if (sdbp_cs_n !== 1'b1 || sdbp_sclk !== 1'b0 || busy !== 1'b0 ||
                frame_done !== 1'b0 || err_overrun !== 1'b0)
                viol++;
        end
        check("idle_violations", viol, 0);

        // Packet 1: bank 0 = address; overrun request and bank-1 fill while it is in flight.
        for (int a = 0; a < N_ZONES; a++) wr(a, 16'(a));
        send_rise(0);
        repeat (1000 - 4) tick();
        sdbpflag = 1'b1;
        repeat (3) tick();
        sdbpflag = 1'b0;
        for (int a = 0; a < N_ZONES; a++) wr(a, 16'hFFFF);
        wait_done(LATENCY + 100);
        check("overrun_pulses_pkt1", ov_count, 1);

        // Packet 2: bank 1 all FFFF; out-of-range writes and zone 359 land in bank 0 meanwhile.
        send_rise(1);
        wr(360, 16'h1234);
        wr(1023, 16'h1234);
        wr(359, 16'h0007);
        wait_done(LATENCY + 100);

        // Packet 3: aborted by a one-cycle reset 5000 cycles in.
        send_rise(2);
        repeat (5000 - 4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cs_n", sdbp_cs_n, 1);
        check("abort_busy", busy, 0);
        check("abort_sclk", sdbp_sclk, 0);
        check("abort_frame_done", frame_done, 0);
        done_before = done_count;
        repeat (200) tick();
        check("abort_no_frame_done", done_count, done_before);

        // Packet 4: full packet after the abort, from bank 0 with zone 359 = 7.
        send_rise(2);
        wait_done(LATENCY + 100);

        check("total_frame_done", done_count, 3);
        check("total_overrun_pulses", ov_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
